// File: rtl/edge_pkg.sv
// Shared operator encodings and datapath width offsets for the edge filter.
package edge_pkg;

    typedef enum logic [1:0] {
        MODE_SOBEL_L1   = 2'd0,
        MODE_SOBEL_MAX  = 2'd1,
        MODE_PREWITT_L1 = 2'd2,
        MODE_BYPASS     = 2'd3
    } mode_e;

    // Bits added on top of DATA_WIDTH for each datapath quantity.
    localparam int PSUM_EXTRA = 2;   // a + 2b + c, unsigned
    localparam int GRAD_EXTRA = 4;   // signed gradient Gx / Gy
    localparam int ABS_EXTRA  = 3;   // |G| and |Gx|+|Gy|

endpackage

// File: rtl/line_window_3x3.sv
// Raster input counters, two line memories and a 3x3 sliding window whose
// newest tap (row 2, column 2) is the pixel accepted on the same edge.
module line_window_3x3 #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int DATA_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           sof,
    input  logic                           data_en,
    input  logic [DATA_WIDTH-1:0]          pixel_in,
    output logic                           win_valid,
    output logic [9*DATA_WIDTH-1:0]        win_flat,
    output logic [$clog2(IMG_WIDTH)-1:0]   win_x,
    output logic [$clog2(IMG_HEIGHT)-1:0]  win_y,
    output logic                           frame_err
);
    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

    logic [XW-1:0]         x_reg, x_pos, x_next, rd_addr;
    logic [YW-1:0]         y_reg, y_pos, y_next;
    logic                  synced_reg, accept;
    logic [DATA_WIDTH-1:0] line1_mem [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] line0_mem [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] line1_rd_reg, line0_rd_reg;
    logic [DATA_WIDTH-1:0] row_in [3];

    // Pixels are ignored after reset until a frame starts with sof.
    always_comb begin
        accept = data_en && (sof || synced_reg);
        x_pos  = sof ? '0 : x_reg;
        y_pos  = sof ? '0 : y_reg;
        x_next = (x_pos == X_LAST) ? '0 : x_pos + 1'b1;
        y_next = y_pos;
        if (x_pos == X_LAST) begin
            y_next = (y_pos == Y_LAST) ? '0 : y_pos + 1'b1;
        end
        // Prefetch the column the next pixel will land in.
        rd_addr   = accept ? x_next : x_reg;
        row_in[0] = line0_rd_reg;
        row_in[1] = line1_rd_reg;
        row_in[2] = pixel_in;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            line1_mem[x_pos] <= pixel_in;
            line0_mem[x_pos] <= line1_rd_reg;
        end
        line1_rd_reg <= line1_mem[rd_addr];
        line0_rd_reg <= line0_mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_reg      <= '0;
            y_reg      <= '0;
            synced_reg <= 1'b0;
            win_valid  <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            win_valid <= accept;
            if (data_en && sof) begin
                synced_reg <= 1'b1;
                if (x_reg != '0 || y_reg != '0) begin
                    frame_err <= 1'b1;
                end
            end
            if (accept) begin
                x_reg <= x_next;
                y_reg <= y_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            win_x <= x_pos;
            win_y <= y_pos;
        end
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_row
        logic [DATA_WIDTH-1:0] tap_reg [3];
        always_ff @(posedge clk) begin
            if (accept) begin
                tap_reg[0] <= tap_reg[1];
                tap_reg[1] <= tap_reg[2];
                tap_reg[2] <= row_in[gi];
            end
        end
        assign win_flat[(gi*3+0)*DATA_WIDTH +: DATA_WIDTH] = tap_reg[0];
        assign win_flat[(gi*3+1)*DATA_WIDTH +: DATA_WIDTH] = tap_reg[1];
        assign win_flat[(gi*3+2)*DATA_WIDTH +: DATA_WIDTH] = tap_reg[2];
    end

endmodule

// File: rtl/edge_filter_core.sv
// 3x3 Sobel/Prewitt edge magnitude with saturation and thresholding; four
// register stages from accepted pixel to out_valid.
module edge_filter_core
    import edge_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sof,
    input  logic                  data_en,
    input  logic [DATA_WIDTH-1:0] pixel_in,
    input  logic [1:0]            mode,
    input  logic [DATA_WIDTH-1:0] threshold,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] edge_out,
    output logic                  edge_bin,
    output logic                  frame_err
);
    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);
    localparam int PW = DATA_WIDTH + PSUM_EXTRA;
    localparam int GW = DATA_WIDTH + GRAD_EXTRA;
    localparam int AW = DATA_WIDTH + ABS_EXTRA;

    logic                   win_valid;
    logic [9*DATA_WIDTH-1:0] win_flat;
    logic [XW-1:0]          win_x;
    logic [YW-1:0]          win_y;
    logic [DATA_WIDTH-1:0]  w [3][3];

    line_window_3x3 #(
        .IMG_WIDTH (IMG_WIDTH),
        .IMG_HEIGHT(IMG_HEIGHT),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_window (
        .clk      (clk),
        .rst      (rst),
        .sof      (sof),
        .data_en  (data_en),
        .pixel_in (pixel_in),
        .win_valid(win_valid),
        .win_flat (win_flat),
        .win_x    (win_x),
        .win_y    (win_y),
        .frame_err(frame_err)
    );

    for (genvar gi = 0; gi < 9; gi++) begin : g_unpack
        assign w[gi/3][gi%3] = win_flat[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    function automatic logic [PW-1:0] tri_sum(input logic [DATA_WIDTH-1:0] a,
                                               input logic [DATA_WIDTH-1:0] b,
                                               input logic [DATA_WIDTH-1:0] c,
                                               input logic dbl);
        logic [PW-1:0] mid;
        mid = dbl ? (PW'(b) << 1) : PW'(b);
        return PW'(a) + mid + PW'(c);
    endfunction

    function automatic logic [AW-1:0] abs_grad(input logic [PW-1:0] pos,
                                                input logic [PW-1:0] neg);
        logic signed [GW-1:0] diff;
        diff = $signed(GW'(pos)) - $signed(GW'(neg));
        return diff[GW-1] ? AW'(-diff) : AW'(diff);
    endfunction

    // Operator settings travel with each pixel so a new frame's settings
    // never leak into the previous frame's tail still in the pipeline.
    mode_e                 mode_reg, cur_mode, s1_mode_reg, s2_mode_reg, s3_mode_reg;
    logic [DATA_WIDTH-1:0] thr_reg, cur_thr, s1_thr_reg, s2_thr_reg, s3_thr_reg;

    always_comb begin
        cur_mode = (data_en && sof) ? mode_e'(mode) : mode_reg;
        cur_thr  = (data_en && sof) ? threshold : thr_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_reg <= MODE_SOBEL_L1;
            thr_reg  <= '0;
        end else if (data_en && sof) begin
            mode_reg <= mode_e'(mode);
            thr_reg  <= threshold;
        end
        if (data_en) begin
            s1_mode_reg <= cur_mode;
            s1_thr_reg  <= cur_thr;
        end
    end

    // S2: positive / negative partial sums of both gradients.
    logic                  s2_valid_reg, s2_border_reg;
    logic [DATA_WIDTH-1:0] s2_center_reg;
    logic [PW-1:0]         s2_gx_pos_reg, s2_gx_neg_reg, s2_gy_pos_reg, s2_gy_neg_reg;
    logic                  dbl;

    assign dbl = (s1_mode_reg != MODE_PREWITT_L1);

    always_ff @(posedge clk) begin
        if (rst) s2_valid_reg <= 1'b0;
        else     s2_valid_reg <= win_valid;
        if (win_valid) begin
            s2_border_reg <= (win_x < XW'(2)) || (win_y < YW'(2));
            s2_center_reg <= w[1][1];
            s2_mode_reg   <= s1_mode_reg;
            s2_thr_reg    <= s1_thr_reg;
            s2_gx_pos_reg <= tri_sum(w[0][2], w[1][2], w[2][2], dbl);
            s2_gx_neg_reg <= tri_sum(w[0][0], w[1][0], w[2][0], dbl);
            s2_gy_pos_reg <= tri_sum(w[2][0], w[2][1], w[2][2], dbl);
            s2_gy_neg_reg <= tri_sum(w[0][0], w[0][1], w[0][2], dbl);
        end
    end

    // S3: signed difference and absolute value.
    logic                  s3_valid_reg, s3_border_reg;
    logic [DATA_WIDTH-1:0] s3_center_reg;
    logic [AW-1:0]         s3_gx_abs_reg, s3_gy_abs_reg;

    always_ff @(posedge clk) begin
        if (rst) s3_valid_reg <= 1'b0;
        else     s3_valid_reg <= s2_valid_reg;
        if (s2_valid_reg) begin
            s3_border_reg <= s2_border_reg;
            s3_center_reg <= s2_center_reg;
            s3_mode_reg   <= s2_mode_reg;
            s3_thr_reg    <= s2_thr_reg;
            s3_gx_abs_reg <= abs_grad(s2_gx_pos_reg, s2_gx_neg_reg);
            s3_gy_abs_reg <= abs_grad(s2_gy_pos_reg, s2_gy_neg_reg);
        end
    end

    // S4: combine, saturate, threshold, border mask.
    logic [AW-1:0]         mag_next;
    logic [DATA_WIDTH-1:0] sat_next;

    always_comb begin
        case (s3_mode_reg)
            MODE_SOBEL_MAX: mag_next = (s3_gx_abs_reg > s3_gy_abs_reg) ? s3_gx_abs_reg : s3_gy_abs_reg;
            MODE_BYPASS:    mag_next = AW'(s3_center_reg);
            default:        mag_next = s3_gx_abs_reg + s3_gy_abs_reg;
        endcase
        sat_next = (|mag_next[AW-1:DATA_WIDTH]) ? '1 : mag_next[DATA_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            edge_out  <= '0;
            edge_bin  <= 1'b0;
        end else begin
            out_valid <= s3_valid_reg;
            if (s3_valid_reg) begin
                edge_out <= s3_border_reg ? '0 : sat_next;
                edge_bin <= !s3_border_reg && (sat_next >= s3_thr_reg);
            end
        end
    end

endmodule

// File: tb/tb_edge_filter_core.sv
// Directed frames against a window-level reference model of the edge filter.
module tb_edge_filter_core;
    localparam int W  = 8;
    localparam int H  = 6;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst, sof, data_en;
    logic [DW-1:0] pixel_in, threshold;
    logic [1:0]    mode;
    logic          out_valid, edge_bin, frame_err;
    logic [DW-1:0] edge_out;

    edge_filter_core #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_WIDTH(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .sof      (sof),
        .data_en  (data_en),
        .pixel_in (pixel_in),
        .mode     (mode),
        .threshold(threshold),
        .out_valid(out_valid),
        .edge_out (edge_out),
        .edge_bin (edge_bin),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        int ev;
        int bv;
    } exp_t;

    exp_t exp_q[$];
    exp_t cmp_item;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   img [H][W];
    int   mx, my, mmode, mthr;
    bit   msync, merr;
    int   rnd_img [W*H];
    int   out_cnt, out_sum, bin_cnt;
    int   out_log [W*H];
    int   log_a [W*H];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end else begin
            $display("ok   %s got=%0d", name, got);
        end
    endtask

    function automatic int pix_of(input int kind, input int x, input int y);
        case (kind)
            0:       return 100;
            1:       return (x >= 4) ? 255 : 0;
            2:       return (x >= 4) ? 50 : 0;
            default: return rnd_img[y*W + x];
        endcase
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        mx = 0; my = 0; mmode = 0; mthr = 0; msync = 0; merr = 0;
    endfunction

    // Expected result straight from the operator definitions on the frame image.
    function automatic void model_accept(input bit s, input int p, input int md, input int th);
        int w [3][3];
        int gx, gy, ax, ay, mag, e, b, k;
        if (s) begin
            if (mx != 0 || my != 0) merr = 1;
            mx = 0; my = 0; mmode = md; mthr = th; msync = 1;
        end
        if (!msync) return;
        img[my][mx] = p;
        e = 0; b = 0;
        if (mx >= 2 && my >= 2) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    w[r][c] = img[my-2+r][mx-2+c];
            k  = (mmode == 2) ? 1 : 2;
            gx = (w[0][2] + k*w[1][2] + w[2][2]) - (w[0][0] + k*w[1][0] + w[2][0]);
            gy = (w[2][0] + k*w[2][1] + w[2][2]) - (w[0][0] + k*w[0][1] + w[0][2]);
            ax = (gx < 0) ? -gx : gx;
            ay = (gy < 0) ? -gy : gy;
            case (mmode)
                1:       mag = (ax > ay) ? ax : ay;
                3:       mag = w[1][1];
                default: mag = ax + ay;
            endcase
            e = (mag > 255) ? 255 : mag;
            b = (e >= mthr) ? 1 : 0;
        end
        exp_q.push_back('{due: cyc + 4, ev: e, bv: b});
        mx++;
        if (mx == W) begin
            mx = 0;
            my = (my == H-1) ? 0 : my + 1;
        end
    endfunction

    task automatic drive(input bit en, input bit s, input int p, input int md, input int th);
        data_en   = en;
        sof       = s;
        pixel_in  = 8'(p);
        mode      = 2'(md);
        threshold = 8'(th);
        if (en) model_accept(s, p, md, th);
        @(posedge clk); #1;
        data_en = 1'b0;
        sof     = 1'b0;
    endtask

    // Non-sof pixels carry different mode/threshold, which must be ignored.
    task automatic send_frame(input int kind, input int md, input int th, input int gap_pct, input int npix);
        int n;
        bit first;
        n = 0;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                if (n < npix) begin
                    while (int'($urandom_range(99)) < gap_pct) drive(0, 0, 0, md, th);
                    first = (x == 0 && y == 0);
                    drive(1, first, pix_of(kind, x, y), first ? md : 3 - md, first ? th : 255 - th);
                end
                n++;
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        check("drain_pending", exp_q.size(), 0);
    endtask

    task automatic clear_stats();
        out_cnt = 0; out_sum = 0; bin_cnt = 0;
    endtask

    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            if (out_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL out_unexpected cyc=%0d edge_out=%0d", cyc, edge_out);
                end else begin
                    cmp_item = exp_q.pop_front();
                    if (cmp_item.due != cyc || int'(edge_out) != cmp_item.ev || int'(edge_bin) != cmp_item.bv) begin
                        errors++;
                        $display("FAIL out_value cyc=%0d got edge=%0d bin=%0d want edge=%0d bin=%0d due=%0d",
                                 cyc, edge_out, edge_bin, cmp_item.ev, cmp_item.bv, cmp_item.due);
                    end else begin
                        $display("out  cyc=%0d edge=%0d bin=%0d", cyc, edge_out, edge_bin);
                    end
                end
                if (out_cnt < W*H) out_log[out_cnt] = int'(edge_out);
                out_cnt++;
                out_sum += int'(edge_out);
                bin_cnt += int'(edge_bin);
            end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
                checks++;
                errors++;
                $display("FAIL out_missing cyc=%0d got out_valid=%0b want 1 due=%0d", cyc, out_valid, exp_q[0].due);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        int mism;
        rst = 1'b1; sof = 1'b0; data_en = 1'b0; pixel_in = '0; mode = '0; threshold = '0;
        model_reset();
        for (int i = 0; i < W*H; i++) rnd_img[i] = int'($urandom_range(255));
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_edge_out",  int'(edge_out),  0);
        check("reset_edge_bin",  int'(edge_bin),  0);
        check("reset_frame_err", int'(frame_err), 0);
        rst = 1'b0;

        clear_stats(); send_frame(0, 0, 50, 0, W*H); drain();
        check("flat_count", out_cnt, 48);
        check("flat_sum",   out_sum, 0);

        clear_stats(); send_frame(1, 0, 128, 0, W*H); drain();
        check("step255_l1_sum",  out_sum, 2040);
        check("step255_l1_bins", bin_cnt, 8);

        clear_stats(); send_frame(2, 1, 128, 0, W*H); drain();
        check("step50_max_sum",  out_sum, 1600);
        check("step50_max_bins", bin_cnt, 8);

        clear_stats(); send_frame(2, 2, 128, 0, W*H); drain();
        check("step50_prewitt_sum",  out_sum, 1200);
        check("step50_prewitt_bins", bin_cnt, 8);

        clear_stats(); send_frame(2, 3, 40, 0, W*H); drain();
        check("step50_bypass_sum",  out_sum, 600);
        check("step50_bypass_bins", bin_cnt, 12);

        clear_stats(); send_frame(3, 0, 100, 0, W*H); drain();
        for (int i = 0; i < W*H; i++) log_a[i] = out_log[i];
        clear_stats(); send_frame(3, 0, 100, 50, W*H); drain();
        check("gap_count", out_cnt, 48);
        mism = 0;
        for (int i = 0; i < W*H; i++) if (out_log[i] != log_a[i]) mism++;
        check("gap_equiv_mismatches", mism, 0);

        check("frame_err_clean", int'(frame_err), 0);
        clear_stats(); send_frame(0, 0, 50, 0, 20); drain();
        clear_stats(); send_frame(1, 0, 128, 0, W*H); drain();
        check("frame_err_set",      int'(frame_err), 1);
        check("frame_err_model",    int'(merr), 1);
        check("restart_step_sum",   out_sum, 2040);
        clear_stats(); send_frame(0, 0, 50, 0, W*H); drain();
        check("frame_err_sticky",   int'(frame_err), 1);

        send_frame(1, 0, 128, 0, 30);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_frame_err", int'(frame_err), 0);

        clear_stats();
        for (int i = 0; i < 5; i++) drive(1, 0, 200, 0, 0);
        repeat (6) begin @(posedge clk); #1; end
        check("no_out_before_sof", out_cnt, 0);
        clear_stats(); send_frame(1, 0, 128, 0, W*H); drain();
        check("after_rst_count", out_cnt, 48);
        check("after_rst_sum",   out_sum, 2040);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/edge_filter_core.md
EDGE_FILTER_CORE -- requirements
Module: edge_filter_core

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 640, pixels per line (>=4).
REQ-002 SHALL have parameter IMG_HEIGHT, default 480, lines per frame (>=4).
REQ-003 SHALL have parameter DATA_WIDTH, default 8, pixel bit width (4..12).
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset: one clock, synchronous, active-high.
REQ-006 SHALL have port sof  input  1  start-of-frame, qualified by data_en, marks pixel (0,0).
REQ-007 SHALL have port data_en  input  1  input pixel valid.
REQ-008 SHALL have port pixel_in  input  DATA_WIDTH  grey pixel, raster order.
REQ-009 SHALL have port mode  input  2  operator select (0 Sobel L1, 1 Sobel max, 2 Prewitt L1, 3 bypass).
REQ-010 SHALL have port threshold  input  DATA_WIDTH  binarisation level.
REQ-011 SHALL have port out_valid  output  1  result valid.
REQ-012 SHALL have port edge_out  output  DATA_WIDTH  saturated magnitude.
REQ-013 SHALL have port edge_bin  output  1  edge_out >= threshold.
REQ-014 SHALL have port frame_err  output  1  sticky: sof arrived with input counters not at (0,0).

Function
REQ-015 SHALL keep input counters x_in, y_in advancing only on data_en, wrapping at IMG_WIDTH-1 / IMG_HEIGHT-1; data_en with sof forces x_in,y_in to (0,0) before advancing.
REQ-016 SHALL form a 3x3 window w[r][c] (r=0 oldest line, c=0 oldest column) whose w[2][2] is the current accepted pixel, using two line memories of IMG_WIDTH entries.
REQ-017 SHALL produce exactly one output per accepted pixel, out_valid asserted exactly 4 cycles after that data_en cycle; gaps in data_en propagate unchanged.
REQ-018 SHALL associate each output with centre pixel (x_in-1, y_in-1); outputs with x_in<2 or y_in<2 SHALL be edge_out=0, edge_bin=0 (border).
REQ-019 Sobel: Gx=(w02+2w12+w22)-(w00+2w10+w20), Gy=(w20+2w21+w22)-(w00+2w01+w02); Prewitt same with weight 1 instead of 2.
REQ-020 SHALL compute Gx, Gy signed DATA_WIDTH+4 bits, |Gx|,|Gy| unsigned DATA_WIDTH+3 bits, no intermediate overflow.
REQ-021 Magnitude: mode 0/2 |Gx|+|Gy|; mode 1 max(|Gx|,|Gy|); mode 3 edge_out=w11 (no arithmetic, border rule still applies).
REQ-022 SHALL saturate magnitude to 2^DATA_WIDTH-1 on edge_out.
REQ-023 SHALL sample mode and threshold only on a data_en&&sof cycle; values hold for the whole frame; changes mid-frame ignored.
REQ-024 Pipeline: S1 window register, S2 positive/negative partial sums, S3 difference and abs, S4 combine, saturate, threshold.
REQ-025 SHALL set frame_err when data_en&&sof occurs with (x_in,y_in)!=(0,0); cleared only by rst; the frame still restarts at (0,0).
REQ-026 Line memories SHALL not be cleared by sof; border rule (REQ-018) masks stale contents.
REQ-027 Last row/column centres (x=IMG_WIDTH-1 or y=IMG_HEIGHT-1) are not emitted; no flush cycles.

Reset
REQ-028 On rst SHALL clear out_valid=0, edge_out=0, edge_bin=0, frame_err=0, counters to (0,0), pipeline valids 0, sampled mode=0, threshold=0.
REQ-029 rst mid-frame SHALL discard all in-flight results; first output after rst requires a new frame beginning at sof.
REQ-030 Line memory contents SHALL not require reset.

Structure
REQ-031 Package edge_pkg SHALL hold mode encodings (MODE_SOBEL_L1, MODE_SOBEL_MAX, MODE_PREWITT_L1, MODE_BYPASS) and gradient-width constants.
REQ-032 Window generator SHALL be sub-module line_window_3x3 (line memories, column shift registers, window valid); arithmetic stays in edge_filter_core.

Verification (IMG_WIDTH=8, IMG_HEIGHT=6, DATA_WIDTH=8)
REQ-033 Flat frame all 100, mode 0 -> every out_valid edge_out=0, 48 outputs per frame, each 4 cycles after its input.
REQ-034 Vertical step cols 0-3=0, 4-7=255, mode 0, threshold 128 -> centres x=3,4 (y>=1) edge_out=255, edge_bin=1; others 0.
REQ-035 Same step with 50, mode 1 -> centres x=3,4 edge_out=200; mode 2 -> 150; mode 3 -> edge_out equals centre pixel.
REQ-036 Random data_en gaps (~50%) -> output sequence identical to gap-free run; latency still 4 cycles per pixel.
REQ-037 sof at pixel 20 of a frame -> frame_err=1 sticky; following outputs treated as rows 0-1 border (zeros); rst mid-frame -> out_valid=0 next cycle, frame_err=0.
